// File: rtl/spdif_pkg.sv
// -----------------------------------------------------------------------------
// spdif_pkg
// Shared S/PDIF types and constants, used by the sample feeder, the
// transmitter and a future receiver.
//   sample_t         : one 24-bit signed, LSB-aligned audio sample
//   stereo_t         : one left/right pair as it travels through the feeder
//   feeder_state_e   : sample feeder FSM states
//   SPDIF_FRAME_CLKS : clocks per S/PDIF frame at 12.288 MHz
// -----------------------------------------------------------------------------
package spdif_pkg;

    typedef logic [23:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feeder_state_e;

    localparam int SPDIF_FRAME_CLKS = 128;

endpackage

// File: rtl/spdif_sample_feeder_if.sv
// -----------------------------------------------------------------------------
// spdif_sample_feeder_if
// Valid/ready stream of stereo pairs from the mixer output bus into the
// S/PDIF sample feeder.
//   s_valid : upstream pair valid                 (master -> slave)
//   s_ready : feeder can accept a pair            (slave  -> master)
//   s_left  : left sample, signed, LSB-aligned    (master -> slave)
//   s_right : right sample, signed, LSB-aligned   (master -> slave)
// -----------------------------------------------------------------------------
interface spdif_sample_feeder_if;
    import spdif_pkg::*;

    logic    s_valid;
    logic    s_ready;
    sample_t s_left;
    sample_t s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/spdif_pair_fifo.sv
// -----------------------------------------------------------------------------
// spdif_pair_fifo
// Synchronous FIFO of stereo pairs with first-word-fall-through read data.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (empties the FIFO)
//   push_i   : write wdata_i; ignored when full, even if a pop happens
//   pop_i    : drop the head entry; ignored when empty
//   wdata_i  : pair to write
//   rdata_o  : head entry (valid while !empty_o)
//   full_o   : level_o == DEPTH
//   empty_o  : level_o == 0
//   level_o  : occupancy, 0..DEPTH inclusive
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 4.
// -----------------------------------------------------------------------------
module spdif_pair_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  stereo_t                  wdata_i,
    output stereo_t                  rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    stereo_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // reads are qualified by the level.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spdif_sample_feeder.sv
// -----------------------------------------------------------------------------
// spdif_sample_feeder
// Upstream stage of the S/PDIF transmitter. Buffers stereo pairs from the
// mixer and hands one pair to the transmitter on each rising edge of its
// datareq level. Starts muted (FILL) until PRIME_LEVEL pairs are buffered,
// then runs; an empty FIFO at request time in RUN is an underrun, which is
// counted and sends the feeder back to FILL.
//
// Ports:
//   clk            : 12.288 MHz clock, shared with the transmitter
//   reset          : synchronous, active-high
//   s_if           : slave side of the mixer valid/ready pair stream
//   datareq        : request level from the transmitter
//   ldataout       : left sample to the transmitter
//   rdataout       : right sample to the transmitter
//   level          : current FIFO occupancy
//   underrun_count : saturating count of underruns seen in RUN
//   running        : high in RUN
//
// Build option:
//   SPDIF_FEEDER_HOLD_EN : when defined, requests that cannot pop (FILL or
//   underrun) keep the last popped pair on the outputs instead of muting.
//   Outputs are zero out of reset, so FILL after reset still reads 0/0.
// -----------------------------------------------------------------------------
module spdif_sample_feeder
    import spdif_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = DEPTH / 2
) (
    input  logic                    clk,
    input  logic                    reset,
    spdif_sample_feeder_if.slave    s_if,
    input  logic                    datareq,
    output sample_t                 ldataout,
    output sample_t                 rdataout,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             underrun_count,
    output logic                    running
);

    localparam int                LW       = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]     PRIME_LV = LW'(PRIME_LEVEL);

    feeder_state_e  state_q;
    logic           datareq_q;
    stereo_t        out_q;
    logic [15:0]    underrun_q;

    stereo_t        push_pair;
    stereo_t        head_pair;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LW-1:0]  fifo_level;
    logic           req_edge;
    logic           pop;

    // Only the rising edge of datareq is a request; a held level pops once.
    assign req_edge = datareq && !datareq_q;
    assign pop      = req_edge && (state_q == RUN) && !fifo_empty;

    assign push_pair   = '{left: s_if.s_left, right: s_if.s_right};
    assign s_if.s_ready = !fifo_full;

    spdif_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (s_if.s_valid),
        .pop_i   (pop),
        .wdata_i (push_pair),
        .rdata_o (head_pair),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            datareq_q  <= 1'b0;
            out_q      <= '0;
            underrun_q <= '0;
        end else begin
            datareq_q <= datareq;
            case (state_q)
                FILL: begin
`ifndef SPDIF_FEEDER_HOLD_EN
                    if (req_edge) out_q <= '0;
`endif
                    if (fifo_level >= PRIME_LV) state_q <= RUN;
                end
                RUN: begin
                    if (req_edge) begin
                        if (!fifo_empty) begin
                            out_q <= head_pair;
                        end else begin
                            // Underrun: a pair pushed this same cycle still
                            // goes into the FIFO, it is not bypassed.
`ifndef SPDIF_FEEDER_HOLD_EN
                            out_q <= '0;
`endif
                            if (underrun_q != 16'hFFFF)
                                underrun_q <= underrun_q + 16'd1;
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign ldataout       = out_q.left;
    assign rdataout       = out_q.right;
    assign level          = fifo_level;
    assign underrun_count = underrun_q;
    assign running        = (state_q == RUN);

endmodule

// File: tb/tb_spdif_sample_feeder.sv
module tb_spdif_sample_feeder;
    import spdif_pkg::*;

    localparam int DEPTH = 8;
    localparam int PRIME = DEPTH / 2;
`ifdef SPDIF_FEEDER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        datareq = 1'b0;
    sample_t     ldataout, rdataout;
    logic [3:0]  level;
    logic [15:0] underrun_count;
    logic        running;

    spdif_sample_feeder_if s_if();

    spdif_sample_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_if           (s_if),
        .datareq        (datareq),
        .ldataout       (ldataout),
        .rdataout       (rdataout),
        .level          (level),
        .underrun_count (underrun_count),
        .running        (running)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit preload_req = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of pairs + running flag ----
    logic [47:0] m_q[$];
    bit          m_run = 1'b0;
    sample_t     m_l = '0, m_r = '0;
    int          m_cnt = 0;
    bit          m_dq = 1'b0;

    always @(posedge clk) begin : model
        int          lvl0;
        bit          req, acc;
        logic [47:0] w;
        if (reset) begin
            m_q.delete();
            m_run = 1'b0;
            m_l = '0; m_r = '0;
            m_cnt = 0;
            m_dq = 1'b0;
        end else begin
            if (preload_req) m_cnt = 65533;
            lvl0 = m_q.size();
            req  = datareq && !m_dq;
            m_dq = datareq;
            acc  = s_if.s_valid && (lvl0 < DEPTH);
            if (req) begin
                if (m_run && lvl0 > 0) begin
                    w = m_q.pop_front();
                    m_l = w[47:24];
                    m_r = w[23:0];
                end else begin
                    if (m_run) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    if (!HOLD) begin m_l = '0; m_r = '0; end
                end
            end
            if (acc) m_q.push_back({s_if.s_left, s_if.s_right});
            if (m_run) begin
                if (req && lvl0 == 0) m_run = 1'b0;
            end else if (lvl0 >= PRIME) begin
                m_run = 1'b1;
            end
        end
    end

    // ---------------- every-cycle comparison against the model ------------
    always @(negedge clk) begin
        cmp("s_ready",  32'(s_if.s_ready), 32'(m_q.size() < DEPTH));
        cmp("level",    32'(level),        32'(m_q.size()));
        cmp("ldataout", 32'(ldataout),     32'(m_l));
        cmp("rdataout", 32'(rdataout),     32'(m_r));
        cmp("running",  32'(running),      32'(m_run));
        if (!preload_req) cmp("underrun_count", 32'(underrun_count), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic req_pulse();
        datareq = 1'b1; cyc(1);
        datareq = 1'b0; cyc(1);
    endtask

    task automatic push4(input sample_t base);
        for (int i = 0; i < 4; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_left  = base + 24'(i);
            s_if.s_right = ~(base + 24'(i));
            cyc(1);
        end
        s_if.s_valid = 1'b0;
    endtask

    initial begin
        sample_t exp_l [3];
        int acc;
        int dr_left, gap;
        int rate [4];

        s_if.s_valid = 1'b0;
        s_if.s_left  = '0;
        s_if.s_right = '0;
        cyc(3);
        cmp("rst_level",    32'(level), 0);
        cmp("rst_ldata",    32'(ldataout), 0);
        cmp("rst_running",  32'(running), 0);
        cmp("rst_s_ready",  32'(s_if.s_ready), 1);
        cmp("rst_underrun", 32'(underrun_count), 0);
        reset = 1'b0;

        // Request while FILL and empty: muted, no count.
        datareq = 1'b1; cyc(1);
        cmp("fill_req_ldata", 32'(ldataout), 0);
        cmp("fill_req_cnt",   32'(underrun_count), 0);
        datareq = 1'b0; cyc(1);

        // Prime with 4 pairs.
        for (int i = 1; i <= 4; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_left  = 24'(i);
            s_if.s_right = 24'h800000 | 24'(i);
            cyc(1);
        end
        s_if.s_valid = 1'b0;
        cmp("prime_level", 32'(level), 4);
        cyc(1);
        cmp("prime_running", 32'(running), 1);

        // First request pops the oldest pair one clock after datareq rises;
        // held for a second cycle it must not pop again.
        datareq = 1'b1; cyc(1);
        cmp("first_ldata", 32'(ldataout), 32'h000001);
        cmp("first_rdata", 32'(rdataout), 32'h800001);
        cmp("first_level", 32'(level), 3);
        cyc(1);
        cmp("held_level", 32'(level), 3);
        cmp("held_ldata", 32'(ldataout), 32'h000001);
        datareq = 1'b0; cyc(1);

        // Push and pop in the same cycle at level 3.
        s_if.s_valid = 1'b1;
        s_if.s_left  = 24'h123456;
        s_if.s_right = 24'h654321;
        datareq = 1'b1; cyc(1);
        s_if.s_valid = 1'b0;
        cmp("pp_level", 32'(level), 3);
        cmp("pp_ldata", 32'(ldataout), 32'h000002);
        datareq = 1'b0; cyc(1);

        // Drain; order must be preserved.
        exp_l[0] = 24'h000003; exp_l[1] = 24'h000004; exp_l[2] = 24'h123456;
        for (int i = 0; i < 3; i++) begin
            datareq = 1'b1; cyc(1);
            cmp("drain_ldata", 32'(ldataout), 32'(exp_l[i]));
            datareq = 1'b0; cyc(1);
        end

        // Underrun: mute (or hold last pair), count, fall back to FILL.
        datareq = 1'b1; cyc(1);
        cmp("ur_ldata",   32'(ldataout), HOLD ? 32'h123456 : 32'h0);
        cmp("ur_rdata",   32'(rdataout), HOLD ? 32'h654321 : 32'h0);
        cmp("ur_count",   32'(underrun_count), 1);
        cmp("ur_running", 32'(running), 0);
        datareq = 1'b0; cyc(1);

        // Refill resumes RUN.
        push4(24'h000100);
        cyc(1);
        cmp("refill_running", 32'(running), 1);

        // Full backpressure from a clean start, no requests.
        reset = 1'b1; cyc(2); reset = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_left  = 24'(32'h10 + i);
            s_if.s_right = 24'(32'h20 + i);
            if (s_if.s_ready) acc++;
            cyc(1);
        end
        s_if.s_valid = 1'b0;
        cmp("full_accepted", 32'(acc), 8);
        cmp("full_level",    32'(level), 8);
        cmp("full_s_ready",  32'(s_if.s_ready), 0);

        // Drain all 8, then preload the counter near saturation.
        for (int i = 0; i < 8; i++) req_pulse();
        force dut.underrun_q = 16'hFFFD;
        preload_req = 1'b1;
        #1;
        release dut.underrun_q;
        cyc(1);
        preload_req = 1'b0;
        req_pulse();                       // -> FFFE
        for (int r = 0; r < 2; r++) begin  // -> FFFF, then stays
            push4(24'h000200);
            cyc(1);
            for (int i = 0; i < 4; i++) req_pulse();
            req_pulse();
        end
        cmp("sat_count", 32'(underrun_count), 32'hFFFF);

        // Randomized traffic with a mid-run reset.
        reset = 1'b1; cyc(2); reset = 1'b0;
        rate[0] = 80; rate[1] = 20; rate[2] = 50; rate[3] = 95;
        dr_left = 0; gap = 0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1000; c++) begin
                s_if.s_valid = ($urandom_range(0, 99) < rate[seg]);
                s_if.s_left  = 24'($urandom);
                s_if.s_right = 24'($urandom);
                if (dr_left > 0) begin
                    datareq = 1'b1; dr_left--;
                end else if (gap > 0) begin
                    datareq = 1'b0; gap--;
                end else begin
                    dr_left = $urandom_range(1, 3) - 1;
                    gap     = $urandom_range(1, 12);
                    datareq = 1'b1;
                end
                reset = (seg == 2 && c == 500);
                cyc(1);
            end
        end
        reset = 1'b0;
        s_if.s_valid = 1'b0;
        datareq = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
